// File: rtl/bram_pkg.sv
// ============================================================================
//  Package : bram_pkg
//  Shared widths, checker state codes and the BRAM test pattern (word k == k).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_pkg;

  localparam int BRAM_DATA_WIDTH = 16;
  localparam int BRAM_MEM_SIZE   = 2**12 - 1;
  localparam int BRAM_ADDR_WIDTH = $clog2(BRAM_MEM_SIZE);

  localparam logic [1:0] CHK_IDLE   = 2'd0;
  localparam logic [1:0] CHK_CHECK  = 2'd1;
  localparam logic [1:0] CHK_REPORT = 2'd2;

  // Callers zero-extend the index in and truncate the result to their word width.
  function automatic logic [31:0] exp_word(input logic [31:0] idx);
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stall_wdog.sv
// ============================================================================
//  Module  : stall_wdog
//  Clearable idle-cycle counter; flags the TIMEOUT_CYC-th consecutive enabled cycle.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_wdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;

  // Look-ahead so the owner can leave on the very edge that completes the count.
  assign o_expired = i_en && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en && (cnt_q != CW'(TIMEOUT_CYC))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bram_rd_checker.sv
// ============================================================================
//  Module  : bram_rd_checker
//  Checks the BRAM read-back stream against the k==k pattern and holds a result.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_rd_checker
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH  = BRAM_DATA_WIDTH,
  parameter int MEM_SIZE    = BRAM_MEM_SIZE,
  parameter int ADDR_WIDTH  = $clog2(MEM_SIZE),
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH-1:0]            i_cnt,
  input  logic                             i_valid,
  input  logic [DATA_WIDTH-1:0]            i_data,
  output logic                             o_busy,
  output logic                             o_res_valid,
  input  logic                             i_res_ready,
  output logic                             o_pass,
  output logic                             o_timeout,
  output logic [ADDR_WIDTH-1:0]            o_err_cnt,
  output logic [ADDR_WIDTH-1:0]            o_first_err_idx,
  output logic [ADDR_WIDTH-1:0]            o_rx_cnt,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] o_sum
);

  localparam int SUM_W = DATA_WIDTH + ADDR_WIDTH;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] err_q, err_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic                  timeout_q, timeout_d;
  logic                  pass_q, pass_d;
  logic                  busy_q, busy_d;
  logic                  res_valid_q, res_valid_d;

  logic                  w_start_ok;
  logic                  w_mismatch;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_err_next;
  logic                  w_wdog_en;
  logic                  w_wdog_clr;
  logic                  w_wdog_expired;

  assign w_start_ok = i_start && (i_cnt != '0);
  assign w_mismatch = (i_data != DATA_WIDTH'(exp_word(32'(idx_q))));
  assign w_last     = (ADDR_WIDTH'(idx_q + 1'b1) == cnt_q);
  assign w_err_next = w_mismatch ? ADDR_WIDTH'(err_q + 1'b1) : err_q;

  assign w_wdog_en  = (state_q == CHK_CHECK) && !i_valid;
  assign w_wdog_clr = ((state_q == CHK_CHECK) && i_valid) ||
                      ((state_q == CHK_IDLE) && w_start_ok);

  stall_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_wdog_en),
    .i_clr     (w_wdog_clr),
    .o_expired (w_wdog_expired)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    err_d       = err_q;
    first_d     = first_q;
    sum_d       = sum_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;
    busy_d      = busy_q;
    res_valid_d = res_valid_q;

    case (state_q)
      CHK_IDLE: begin
        if (w_start_ok) begin
          state_d     = CHK_CHECK;
          cnt_d       = i_cnt;
          idx_d       = '0;
          err_d       = '0;
          first_d     = '0;
          sum_d       = '0;
          timeout_d   = 1'b0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          res_valid_d = 1'b0;
        end
      end

      CHK_CHECK: begin
        if (i_valid) begin
          idx_d = ADDR_WIDTH'(idx_q + 1'b1);
          sum_d = sum_q + SUM_W'(i_data);
          err_d = w_err_next;
          if (w_mismatch && (err_q == '0)) begin
            first_d = idx_q;
          end
          if (w_last) begin
            state_d     = CHK_REPORT;
            pass_d      = (w_err_next == '0);
            busy_d      = 1'b0;
            res_valid_d = 1'b1;
          end
        end else if (w_wdog_expired) begin
          state_d     = CHK_REPORT;
          timeout_d   = 1'b1;
          pass_d      = 1'b0;
          busy_d      = 1'b0;
          res_valid_d = 1'b1;
        end
      end

      CHK_REPORT: begin
        if (i_res_ready) begin
          state_d     = CHK_IDLE;
          res_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = CHK_IDLE;
        busy_d      = 1'b0;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CHK_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      err_q       <= '0;
      first_q     <= '0;
      sum_q       <= '0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      first_q     <= first_d;
      sum_q       <= sum_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign o_busy          = busy_q;
  assign o_res_valid     = res_valid_q;
  assign o_pass          = pass_q;
  assign o_timeout       = timeout_q;
  assign o_err_cnt       = err_q;
  assign o_first_err_idx = first_q;
  assign o_rx_cnt        = idx_q;
  assign o_sum           = sum_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_rd_checker.sv
// ============================================================================
//  Module  : tb_bram_rd_checker
//  Directed and randomized checks of bram_rd_checker against a list-based model.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_rd_checker;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int SW = DW + AW;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_cnt = '0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_res_ready = 1'b0;
  logic          o_busy, o_res_valid, o_pass, o_timeout;
  logic [AW-1:0] o_err_cnt, o_first_err_idx, o_rx_cnt;
  logic [SW-1:0] o_sum;

  int n_cmp = 0;
  int n_bad = 0;

  int     m_err, m_first, m_rx;
  longint m_sum;
  bit     m_to, m_pass;

  always #5 clk = ~clk;

  bram_rd_checker #(
    .DATA_WIDTH (DW),
    .MEM_SIZE   (4095),
    .ADDR_WIDTH (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_cnt          (i_cnt),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .o_busy         (o_busy),
    .o_res_valid    (o_res_valid),
    .i_res_ready    (i_res_ready),
    .o_pass         (o_pass),
    .o_timeout      (o_timeout),
    .o_err_cnt      (o_err_cnt),
    .o_first_err_idx(o_first_err_idx),
    .o_rx_cnt       (o_rx_cnt),
    .o_sum          (o_sum)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: results follow directly from the list of words actually delivered.
  function automatic void model(input int cnt, input logic [DW-1:0] w[$]);
    m_err   = 0;
    m_first = 0;
    m_sum   = 0;
    m_rx    = w.size();
    m_to    = (w.size() < cnt);
    foreach (w[k]) begin
      if (w[k] != DW'(k)) begin
        if (m_err == 0) m_first = k;
        m_err++;
      end
      m_sum += longint'(w[k]);
    end
    m_pass = (m_err == 0) && !m_to;
  endfunction

  task automatic check_res(input string p);
    chk({p, "_res_valid"}, o_res_valid, 1);
    chk({p, "_busy"},      o_busy, 0);
    chk({p, "_pass"},      o_pass, m_pass);
    chk({p, "_timeout"},   o_timeout, m_to);
    chk({p, "_err_cnt"},   o_err_cnt, m_err);
    chk({p, "_first_err"}, o_first_err_idx, m_first);
    chk({p, "_rx_cnt"},    o_rx_cnt, m_rx);
    chk({p, "_sum"},       o_sum, m_sum);
  endtask

  task automatic start_run(input int cnt);
    i_cnt = AW'(cnt); i_start = 1'b1;
    tick();
    i_start = 1'b0; i_cnt = '0;
    chk("start_busy", o_busy, 1);
    chk("start_rx_clear", o_rx_cnt, 0);
  endtask

  task automatic send_words(input logic [DW-1:0] w[$], input int from, input int upto,
                            input bit gaps);
    for (int k = from; k < upto; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin i_valid = 1'b0; tick(); end
      end
      if (k == upto - 1) chk("no_early_res", o_res_valid, 0);
      i_valid = 1'b1; i_data = w[k];
      tick();
    end
    i_valid = 1'b0; i_data = '0;
  endtask

  task automatic release_res(input string p);
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;
    chk({p, "_rel_res_valid"}, o_res_valid, 0);
    chk({p, "_rel_busy"}, o_busy, 0);
  endtask

  initial begin
    logic [DW-1:0] w[$];
    int n;
    int cnt;

    // Reset state
    repeat (2) tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_res_valid", o_res_valid, 0);
    chk("rst_pass", o_pass, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_err", o_err_cnt, 0);
    chk("rst_first", o_first_err_idx, 0);
    chk("rst_rx", o_rx_cnt, 0);
    chk("rst_sum", o_sum, 0);
    rst_n = 1'b1;
    tick();

    // Clean run, back-to-back words
    w.delete();
    for (int k = 0; k < 8; k++) w.push_back(DW'(k));
    model(8, w);
    start_run(8);
    send_words(w, 0, 8, 1'b0);
    check_res("clean");
    chk("clean_sum_28", o_sum, 28);
    release_res("clean");

    // Corrupted words 5 and 9
    w.delete();
    for (int k = 0; k < 16; k++) w.push_back(DW'(k));
    w[5] = 16'hFFFF;
    w[9] = 16'h0000;
    model(16, w);
    start_run(16);
    send_words(w, 0, 16, 1'b1);
    check_res("corrupt");
    chk("corrupt_sum_65641", o_sum, 65641);
    release_res("corrupt");

    // Stall after four words
    w.delete();
    for (int k = 0; k < 4; k++) w.push_back(DW'(k));
    model(10, w);
    start_run(10);
    send_words(w, 0, 4, 1'b0);
    n = 0;
    while (!o_res_valid && n < 200) begin tick(); n++; end
    chk("stall_latency", n, TO);
    check_res("stall");
    release_res("stall");

    // Zero-count start is ignored
    i_cnt = '0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("zero_start_busy", o_busy, 0);
    chk("zero_start_res_valid", o_res_valid, 0);

    // Start mid-CHECK is ignored
    w.delete();
    for (int k = 0; k < 6; k++) w.push_back(DW'(k));
    model(6, w);
    start_run(6);
    send_words(w, 0, 2, 1'b0);
    i_cnt = AW'(3); i_start = 1'b1;
    tick();
    i_start = 1'b0; i_cnt = '0;
    send_words(w, 2, 3, 1'b0);
    chk("restart_ignored_busy", o_busy, 1);
    chk("restart_ignored_rx", o_rx_cnt, 3);
    send_words(w, 3, 6, 1'b0);
    check_res("restart");

    // Result held while ready is low; stray valids ignored
    for (int c = 0; c < 20; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_data  = DW'($urandom);
      tick();
      chk("hold_res_valid", o_res_valid, 1);
      chk("hold_rx", o_rx_cnt, m_rx);
      chk("hold_sum", o_sum, m_sum);
    end
    i_valid = 1'b0;
    release_res("hold");
    chk("idle_keep_sum", o_sum, m_sum);
    chk("idle_keep_pass", o_pass, 1);
    start_run(5);
    chk("restart_clr_sum", o_sum, 0);
    chk("restart_clr_err", o_err_cnt, 0);
    chk("restart_clr_pass", o_pass, 0);
    w.delete();
    for (int k = 0; k < 5; k++) w.push_back(DW'(k));
    model(5, w);
    send_words(w, 0, 5, 1'b1);
    check_res("after_hold");
    release_res("after_hold");

    // Asynchronous reset mid-CHECK
    w.delete();
    for (int k = 0; k < 10; k++) w.push_back(DW'(k));
    start_run(10);
    send_words(w, 0, 3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_rx", o_rx_cnt, 0);
    chk("arst_sum", o_sum, 0);
    chk("arst_res_valid", o_res_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    w.delete();
    for (int k = 0; k < 4; k++) w.push_back(DW'(k));
    model(4, w);
    start_run(4);
    send_words(w, 0, 4, 1'b0);
    check_res("post_rst");
    chk("post_rst_sum_6", o_sum, 6);
    release_res("post_rst");

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      cnt = $urandom_range(1, 40);
      w.delete();
      for (int k = 0; k < cnt; k++) begin
        if ($urandom_range(0, 3) == 0) w.push_back(DW'($urandom));
        else w.push_back(DW'(k));
      end
      model(cnt, w);
      start_run(cnt);
      send_words(w, 0, cnt, 1'b1);
      check_res("rand");
      repeat ($urandom_range(0, 3)) tick();
      release_res("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
